systolic_input_skewer: RTL and testbench

Upstream feeder for the matrix multiply unit. It accepts one activation column-vector per handshake, delays lane r by r additional cycles, and appends LENGTH-1 zero flush cycles per tile. The result is the diagonally skewed `Inputs`/`EN` stream the systolic array consumes. One tile is exactly LENGTH columns, and the block idles cleanly between tiles.

---
 rtl/systolic_input_skewer.sv | 108 ++++++++++
 tb/tb_systolic_input_skewer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/systolic_input_skewer.sv
// Diagonal input skewer for the systolic matrix multiply array: lane r delays its
// element by r extra advances, and each tile is followed by LENGTH-1 zero flush advances.
module systolic_input_skewer #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 3
) (
  input  logic             CLK,
  input  logic             SYNC_RST,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In_Vector  [0:LENGTH-1],
  output logic [WIDTH-1:0] Out_Inputs [0:LENGTH-1],
  output logic             Out_EN,
  output logic             Tile_Done
);

  localparam logic RUN   = 1'b0;
  localparam logic FLUSH = 1'b1;

  localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CW-1:0] COL_LAST   = CW'(LENGTH - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'((LENGTH > 1) ? LENGTH - 2 : 0);
  localparam logic          SINGLE     = (LENGTH == 1);

  logic          state_reg, state_next;
  logic [CW-1:0] col_cnt_reg, col_cnt_next;
  logic [CW-1:0] flush_cnt_reg, flush_cnt_next;
  logic          accept, advance, done;
  logic          out_en_reg, tile_done_reg;

  assign In_Ready  = (state_reg == RUN);
  assign accept    = (state_reg == RUN) & In_Valid;
  assign advance   = accept | (state_reg == FLUSH);
  assign Out_EN    = out_en_reg;
  assign Tile_Done = tile_done_reg;

  always_comb begin
    state_next     = state_reg;
    col_cnt_next   = col_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    done           = 1'b0;
    case (state_reg)
      RUN: begin
        if (accept) begin
          if (col_cnt_reg == COL_LAST) begin
            col_cnt_next = '0;
            // A one-lane array needs no flush: the tile ends on its only accept.
            if (SINGLE) done = 1'b1;
            else        state_next = FLUSH;
          end else begin
            col_cnt_next = CW'(col_cnt_reg + 1'b1);
          end
        end
      end
      default: begin
        if (flush_cnt_reg == FLUSH_LAST) begin
          flush_cnt_next = '0;
          state_next     = RUN;
          done           = 1'b1;
        end else begin
          flush_cnt_next = CW'(flush_cnt_reg + 1'b1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!SYNC_RST) begin
      state_reg     <= RUN;
      col_cnt_reg   <= '0;
      flush_cnt_reg <= '0;
      out_en_reg    <= 1'b0;
      tile_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      col_cnt_reg   <= col_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
      out_en_reg    <= advance;
      tile_done_reg <= done;
    end
  end

  // Lane gi: (gi+1) stages packed into one vector, stage 0 in the low slice.
  genvar gi;
  generate
    for (gi = 0; gi < LENGTH; gi++) begin : g_lane
      logic [(gi+1)*WIDTH-1:0] shift_reg;
      logic [WIDTH-1:0]        load_val;

      // Flush advances inject zeros so the tail of the tile drains cleanly.
      assign load_val       = accept ? In_Vector[gi] : '0;
      assign Out_Inputs[gi] = shift_reg[(gi+1)*WIDTH-1 -: WIDTH];

      if (gi == 0) begin : g_single
        always_ff @(posedge CLK) begin
          if (!SYNC_RST)    shift_reg <= '0;
          else if (advance) shift_reg <= load_val;
        end
      end else begin : g_multi
        always_ff @(posedge CLK) begin
          if (!SYNC_RST)    shift_reg <= '0;
          else if (advance) shift_reg <= {shift_reg[gi*WIDTH-1:0], load_val};
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Directed bench for systolic_input_skewer (WIDTH=8, LENGTH=3): one line per
// cycle-step, hand-computed lane values, handshake and pulse timing.
module tb_systolic_input_skewer;

  logic       CLK = 1'b0;
  logic       SYNC_RST;
  logic       In_Valid;
  logic       In_Ready;
  logic [7:0] In_Vector  [0:2];
  logic [7:0] Out_Inputs [0:2];
  logic       Out_EN;
  logic       Tile_Done;

  int checks   = 0;
  int failures = 0;

  systolic_input_skewer #(.WIDTH(8), .LENGTH(3)) dut (
    .CLK        (CLK),
    .SYNC_RST   (SYNC_RST),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .In_Vector  (In_Vector),
    .Out_Inputs (Out_Inputs),
    .Out_EN     (Out_EN),
    .Tile_Done  (Tile_Done)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle: check In_Ready before the edge, then the registered outputs after it.
  task automatic step(input string tag, input logic rst_n, input logic v,
                      input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                      input logic exp_rdy, input logic exp_en, input logic exp_done,
                      input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    SYNC_RST     = rst_n;
    In_Valid     = v;
    In_Vector[0] = a0;
    In_Vector[1] = a1;
    In_Vector[2] = a2;
    #1;
    check_val({tag, ".ready"}, {31'd0, In_Ready}, {31'd0, exp_rdy});
    @(posedge CLK);
    #1;
    check_val({tag, ".en"},    {31'd0, Out_EN},    {31'd0, exp_en});
    check_val({tag, ".done"},  {31'd0, Tile_Done}, {31'd0, exp_done});
    check_val({tag, ".lane0"}, {24'd0, Out_Inputs[0]}, {24'd0, e0});
    check_val({tag, ".lane1"}, {24'd0, Out_Inputs[1]}, {24'd0, e1});
    check_val({tag, ".lane2"}, {24'd0, Out_Inputs[2]}, {24'd0, e2});
    $display("step %-10s rst_n=%0b v=%0b in=(%0d,%0d,%0d) rdy=%0b en=%0b done=%0b out=(%0d,%0d,%0d)",
             tag, rst_n, v, a0, a1, a2, In_Ready, Out_EN, Tile_Done,
             Out_Inputs[0], Out_Inputs[1], Out_Inputs[2]);
  endtask

  // Basic tile starting from RUN with lane2 holding `prev2`.
  task automatic basic_tile(input string tag, input logic [7:0] prev2);
    step({tag, "0"}, 1, 1, 1, 4, 7, 1, 1, 0, 1, 0, 0);
    step({tag, "1"}, 1, 1, 2, 5, 8, 1, 1, 0, 2, 4, 0);
    step({tag, "2"}, 1, 1, 3, 6, 9, 1, 1, 0, 3, 5, 7);
    step({tag, "3"}, 1, 0, 0, 0, 0, 0, 1, 0, 0, 6, 8);
    step({tag, "4"}, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 9);
    step({tag, "5"}, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 9);
    if (prev2 != 8'd0) check_val({tag, ".prev"}, {24'd0, prev2}, 32'd9);
  endtask

  initial begin
    SYNC_RST = 1'b0;
    In_Valid = 1'b0;
    for (int i = 0; i < 3; i++) In_Vector[i] = 8'd0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check_val("reset.ready", {31'd0, In_Ready},  32'd1);
    check_val("reset.en",    {31'd0, Out_EN},    32'd0);
    check_val("reset.done",  {31'd0, Tile_Done}, 32'd0);
    check_val("reset.lane0", {24'd0, Out_Inputs[0]}, 32'd0);
    check_val("reset.lane2", {24'd0, Out_Inputs[2]}, 32'd0);

    // Idle: In_Vector wiggles but is never accepted.
    for (int i = 0; i < 20; i++)
      step("idle", 1, 0, 8'(i + 50), 8'(i + 60), 8'(i + 70), 1, 0, 0, 0, 0, 0);

    basic_tile("basic", 8'd0);

    // Stalls between column 1 and column 2; lane2 starts at 9 and drains on first advance.
    step("stall0", 1, 1, 1, 4, 7,    1, 1, 0, 1, 0, 0);
    step("stall1", 1, 0, 99, 99, 99, 1, 0, 0, 1, 0, 0);
    step("stall2", 1, 0, 77, 77, 77, 1, 0, 0, 1, 0, 0);
    step("stall3", 1, 1, 2, 5, 8,    1, 1, 0, 2, 4, 0);
    step("stall4", 1, 1, 3, 6, 9,    1, 1, 0, 3, 5, 7);
    step("stall5", 1, 0, 0, 0, 0,    0, 1, 0, 0, 6, 8);
    step("stall6", 1, 0, 0, 0, 0,    0, 1, 1, 0, 0, 9);
    step("stall7", 1, 0, 0, 0, 0,    1, 0, 0, 0, 0, 9);

    // Back-to-back: tile 2 accepted in the Tile_Done cycle of tile 1.
    step("b2b0", 1, 1, 1, 4, 7,    1, 1, 0, 1, 0, 0);
    step("b2b1", 1, 1, 2, 5, 8,    1, 1, 0, 2, 4, 0);
    step("b2b2", 1, 1, 3, 6, 9,    1, 1, 0, 3, 5, 7);
    step("b2b3", 1, 0, 0, 0, 0,    0, 1, 0, 0, 6, 8);
    step("b2b4", 1, 0, 0, 0, 0,    0, 1, 1, 0, 0, 9);
    step("b2b5", 1, 1, 10, 11, 12, 1, 1, 0, 10, 0, 0);
    step("b2b6", 1, 1, 13, 14, 15, 1, 1, 0, 13, 11, 0);
    step("b2b7", 1, 1, 16, 17, 18, 1, 1, 0, 16, 14, 12);
    step("b2b8", 1, 0, 0, 0, 0,    0, 1, 0, 0, 17, 15);
    step("b2b9", 1, 0, 0, 0, 0,    0, 1, 1, 0, 0, 18);
    step("b2b10", 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 18);

    // Reset after two accepts, with a third column offered at the reset edge.
    step("rmid0", 1, 1, 1, 4, 7, 1, 1, 0, 1, 0, 0);
    step("rmid1", 1, 1, 2, 5, 8, 1, 1, 0, 2, 4, 0);
    step("rmid2", 0, 1, 3, 6, 9, 1, 0, 0, 0, 0, 0);
    step("rmid3", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("rmid4", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("rmid5", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    basic_tile("fresh", 8'd0);

    // Reset on the final flush advance: no Tile_Done, lanes cleared.
    step("rfin0", 1, 1, 1, 4, 7, 1, 1, 0, 1, 0, 0);
    step("rfin1", 1, 1, 2, 5, 8, 1, 1, 0, 2, 4, 0);
    step("rfin2", 1, 1, 3, 6, 9, 1, 1, 0, 3, 5, 7);
    step("rfin3", 1, 0, 0, 0, 0, 0, 1, 0, 0, 6, 8);
    step("rfin4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rfin5", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
